// File: rtl/spi_ram_pkg.sv
// Shared opcodes, frame FSM state type and payload-width helper for spi_ram_slave_p.
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_EXEC,
    ST_TX,
    ST_DONE
  } state_t;

  function automatic int unsigned calc_pw(input int unsigned aw, input int unsigned dw);
    return (aw > dw) ? aw : dw;
  endfunction

endpackage

// File: rtl/spi_ram_mem.sv
// Word memory with write/read address registers, range check and registered read data.
// Optional SPI_RAM_AUTO_INC_EN: post-access address increment with wrap at MEM_DEPTH-1.
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_addr_we,
  input  logic                  i_wr_data_we,
  input  logic                  i_rd_addr_we,
`ifdef SPI_RAM_AUTO_INC_EN
  input  logic                  i_rd_commit,
`endif
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;

  assign w_wr_in_range = ({1'b0, r_wr_addr} < DEPTH_W);
  assign w_rd_in_range = ({1'b0, r_rd_addr} < DEPTH_W);
  assign o_rd_data     = r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_data_we && w_wr_in_range) begin
      r_mem[r_wr_addr] <= i_data;
    end
  end

  // Read port tracks rd_addr every cycle so the word is ready when RD_DATA commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_in_range ? r_mem[r_rd_addr] : '0;
    end
  end

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_rd_next;

  assign w_wr_next = (r_wr_addr == LAST_ADDR) ? '0 : r_wr_addr + 1'b1;
  assign w_rd_next = (r_rd_addr == LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      if (i_wr_addr_we) begin
        r_wr_addr <= i_addr;
      end
`ifdef SPI_RAM_AUTO_INC_EN
      else if (i_wr_data_we) begin
        r_wr_addr <= w_wr_next;
      end
`endif
      if (i_rd_addr_we) begin
        r_rd_addr <= i_addr;
      end
`ifdef SPI_RAM_AUTO_INC_EN
      else if (i_rd_commit) begin
        r_rd_addr <= w_rd_next;
      end
`endif
    end
  end

endmodule

// File: rtl/spi_ram_slave_p.sv
// SPI slave frame engine (2-bit opcode + PW payload, MSB first) with attached word memory.
// Build option SPI_RAM_AUTO_INC_EN enables address auto-increment in spi_ram_mem.
module spi_ram_slave_p
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic frame_err
);

  localparam int unsigned PW = calc_pw(ADDR_WIDTH, DATA_WIDTH);
  localparam int unsigned CW = $clog2(PW) + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [1:0]            r_op;
  logic [PW-1:0]         r_payload;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_miso;
  logic                  r_frame_err;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_abort;
  logic                  w_commit;
  logic                  w_op_last;
  logic                  w_pl_last;
  logic                  w_tx_last;

  assign w_op_last = (r_cnt == CW'(1));
  assign w_pl_last = (r_cnt == CW'(PW - 1));
  assign w_tx_last = (r_cnt == CW'(DATA_WIDTH));
  assign w_commit  = (r_state == ST_EXEC);
  assign MISO      = r_miso;
  assign frame_err = r_frame_err;

  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE:    if (!SS_n) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_op_last) begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_pl_last) begin
          w_state_nxt = ST_EXEC;
        end
      end
      // Commit is unconditional here; a late SS_n only suppresses the TX phase.
      ST_EXEC: begin
        if (SS_n)                     w_state_nxt = ST_IDLE;
        else if (r_op == OP_RD_DATA)  w_state_nxt = ST_TX;
        else                          w_state_nxt = ST_DONE;
      end
      ST_TX: begin
        if (SS_n) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_tx_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:    if (SS_n) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_payload   <= '0;
      r_tx        <= '0;
      r_miso      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_abort;
      r_miso      <= 1'b0;
      case (r_state)
        ST_IDLE: r_cnt <= '0;
        ST_CMD: begin
          if (!SS_n) begin
            r_op  <= {r_op[0], MOSI};
            r_cnt <= w_op_last ? '0 : r_cnt + 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (!SS_n) begin
            r_payload <= {r_payload[PW-2:0], MOSI};
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        // MSB goes straight to MISO; the counter tracks bits already presented.
        ST_EXEC: begin
          if (!SS_n && (r_op == OP_RD_DATA)) begin
            r_miso <= w_rd_data[DATA_WIDTH-1];
            r_tx   <= {w_rd_data[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= CW'(1);
          end
        end
        ST_TX: begin
          if (!SS_n && !w_tx_last) begin
            r_miso <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  spi_ram_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_addr_we (w_commit && (r_op == OP_WR_ADDR)),
    .i_wr_data_we (w_commit && (r_op == OP_WR_DATA)),
    .i_rd_addr_we (w_commit && (r_op == OP_RD_ADDR)),
`ifdef SPI_RAM_AUTO_INC_EN
    .i_rd_commit  (w_commit && (r_op == OP_RD_DATA)),
`endif
    .i_addr       (r_payload[ADDR_WIDTH-1:0]),
    .i_data       (r_payload[DATA_WIDTH-1:0]),
    .o_rd_data    (w_rd_data)
  );

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Scoreboard bench for spi_ram_slave_p: default instance plus a 12-bit/depth-10 instance.
module tb_spi_ram_slave_p;

  localparam logic [1:0] WA = 2'b00;
  localparam logic [1:0] WD = 2'b01;
  localparam logic [1:0] RA = 2'b10;
  localparam logic [1:0] RD = 2'b11;

  typedef struct packed {
    logic miso;
    logic err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic sel = 1'b0;
  logic ss_a, ss_b;
  logic miso_a, err_a, miso_b, err_b;
  logic cur_miso, cur_err;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned pw = 8;
  int unsigned dw = 8;
  string       tag = "reset";

  always #5 clk = ~clk;

  assign ss_a     = sel ? 1'b1 : ss_n;
  assign ss_b     = sel ? ss_n : 1'b1;
  assign cur_miso = sel ? miso_b : miso_a;
  assign cur_err  = sel ? err_b : err_a;

  spi_ram_slave_p #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .MEM_DEPTH  (256)
  ) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_a),
    .MOSI      (mosi),
    .MISO      (miso_a),
    .frame_err (err_a)
  );

  spi_ram_slave_p #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (12),
    .MEM_DEPTH  (10)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (ss_b),
    .MOSI      (mosi),
    .MISO      (miso_b),
    .frame_err (err_b)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s] @%0t: got %b, expected %b", name, tag, $time, act, exp);
    end
  endtask

  // Monitor: one expected output pair per driven cycle, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("miso", cur_miso, e.miso);
        check("frame_err", cur_err, e.err);
      end
    end
  end

  task automatic step(input logic ss, input logic d, input logic em, input logic ee);
    @(negedge clk);
    ss_n = ss;
    mosi = d;
    q.push_back(exp_t'{em, ee});
  endtask

  task automatic send_head(input logic [1:0] op, input logic [15:0] pl, input int unsigned nbits);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, op[1], 1'b0, 1'b0);
    step(1'b0, op[0], 1'b0, 1'b0);
    for (int unsigned i = 0; i < nbits; i++) step(1'b0, pl[pw-1-i], 1'b0, 1'b0);
  endtask

  task automatic idle2();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [1:0] op, input logic [15:0] pl, input logic [15:0] rexp);
    send_head(op, pl, pw);
    if (op == RD) begin
      for (int unsigned k = 0; k < dw; k++) step(1'b0, 1'b0, rexp[dw-1-k], 1'b0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle2();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso_a", miso_a, 1'b0);
    check("rst_err_a", err_a, 1'b0);
    check("rst_miso_b", miso_b, 1'b0);
    check("rst_err_b", err_b, 1'b0);
    rst_n = 1'b1;
    idle2();

    tag = "addr0_default";
    frame(WD, 16'h005A, 16'h0);
    frame(RD, 16'h0000, 16'h005A);

    tag = "write_read";
    frame(WA, 16'h003C, 16'h0);
    frame(WD, 16'h00A5, 16'h0);
    frame(RA, 16'h003C, 16'h0);
    frame(RD, 16'h0000, 16'h00A5);

    tag = "payload_abort";
    send_head(WD, 16'h00FF, 5);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    frame(RA, 16'h003C, 16'h0);
    frame(RD, 16'h0000, 16'h00A5);

    tag = "tx_abort";
    frame(RA, 16'h003C, 16'h0);
    send_head(RD, 16'h0000, pw);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    tag = "exec_race";
    send_head(WA, 16'h0040, pw);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    frame(WD, 16'h009F, 16'h0);
    frame(RA, 16'h0040, 16'h0);

    tag = "reset_in_tx";
    send_head(RD, 16'h0000, pw);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_tx_miso", miso_a, 1'b0);
    check("rst_tx_err", err_a, 1'b0);
    @(negedge clk);
    ss_n  = 1'b1;
    rst_n = 1'b1;
    idle2();
    frame(RD, 16'h0000, 16'h005A);

    tag = "auto_inc";
    frame(WA, 16'h00FF, 16'h0);
    frame(WD, 16'h0011, 16'h0);
    frame(WD, 16'h0022, 16'h0);
    frame(RA, 16'h00FF, 16'h0);
`ifdef SPI_RAM_AUTO_INC_EN
    frame(RD, 16'h0000, 16'h0011);
    frame(RD, 16'h0000, 16'h0022);
`else
    frame(RD, 16'h0000, 16'h0022);
    frame(RA, 16'h0000, 16'h0);
    frame(RD, 16'h0000, 16'h005A);
`endif

    tag = "out_of_range";
    repeat (2) @(negedge clk);
    sel = 1'b1;
    pw  = 12;
    dw  = 12;
    idle2();
    frame(WA, 16'h000C, 16'h0);
    frame(WD, 16'h0ABC, 16'h0);
    frame(WA, 16'h0003, 16'h0);
    frame(WD, 16'h0ABC, 16'h0);
    frame(RA, 16'h000C, 16'h0);
    frame(RD, 16'h0000, 16'h0000);
    frame(RA, 16'h0003, 16'h0);
    frame(RD, 16'h0000, 16'h0ABC);

    repeat (4) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_p.md
Name: spi_ram_slave_p

Overview:
- Parametrised successor to the fixed 10-bit SPI-slave-plus-RAM pair. It merges the serial frame engine and the memory into one block.
- Address width, data width and memory depth are configurable. Adds a frame-abort error flag and optional address auto-increment for burst access.
- Sits directly on the chip SPI pins. SPI bit rate equals clk: one bit is sampled per rising clk edge while SS_n is low.

Parameters:
- ADDR_WIDTH, 8, address bits; MEM_DEPTH must be <= 2**ADDR_WIDTH.
- DATA_WIDTH, 8, memory word width.
- MEM_DEPTH, 256, number of memory words.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low, frames a transaction.
- MOSI  input  1  serial in, MSB first.
- MISO  output  1  serial out, MSB first; registered.
- frame_err  output  1  one-cycle pulse on aborted frame.

Behaviour:
- Derived widths: PW = max(ADDR_WIDTH, DATA_WIDTH). Frame = 2-bit opcode + PW payload bits, MSB first.
- Opcodes:
  - 00 WR_ADDR: wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01 WR_DATA: mem[wr_addr] <= payload[DATA_WIDTH-1:0].
  - 10 RD_ADDR: rd_addr <= payload[ADDR_WIDTH-1:0].
  - 11 RD_DATA: payload is don't-care; returns mem[rd_addr] on MISO.
- FSM states: IDLE, CMD, PAYLOAD, EXEC, TX, DONE.
- Edge numbering: E0 is the first edge where IDLE samples SS_n=0.
  - E0: IDLE->CMD; no bit captured.
  - E1, E2: opcode bits 1, 0 captured.
  - E3..E(2+PW): payload captured; on E(2+PW), state -> EXEC.
  - E(3+PW): commit the opcode action. RD_DATA: load mem[rd_addr] into tx shift register, -> TX. Others: -> DONE.
  - TX: MISO shows bit DATA_WIDTH-1 after E(3+PW), next bit after each following edge. After DATA_WIDTH bits -> DONE.
  - DONE: MISO=0; -> IDLE when SS_n sampled high.
- Defaults (PW=8): commit at E11; MISO bits valid in cycles after E11..E18.
- Bus behaviour: MISO=0 whenever not in TX. MOSI is ignored outside CMD/PAYLOAD.
- Abort: SS_n sampled high in CMD, PAYLOAD or TX -> IDLE next edge, frame_err=1 for one cycle.
  - No commit occurs; addresses and memory are unchanged.
  - A TX already in progress is abandoned and MISO returns to 0.
- Commit/SS_n race: SS_n high at E(3+PW) while in EXEC still commits, then -> IDLE, no TX, no frame_err.
- Out-of-range address (>= MEM_DEPTH): WR_DATA is ignored; RD_DATA returns all zeros.
- Reset values: MISO=0, frame_err=0, state=IDLE, wr_addr=0, rd_addr=0, shift registers 0. Memory contents are not reset.
- Reset mid-frame: immediate return to reset values; no partial write.
- RD_DATA with no prior RD_ADDR reads address 0.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined:
  - Each committed WR_DATA increments wr_addr; each committed RD_DATA increments rd_addr (at the commit edge, after the access).
  - Both wrap from MEM_DEPTH-1 to 0.
- Undefined: addresses change only on WR_ADDR/RD_ADDR.

Decomposition:
- Package spi_ram_pkg holds:
  - opcode localparams OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA;
  - state enum type;
  - helper function computing PW.
- One sub-module, spi_ram_mem:
  - contains the memory array, wr_addr/rd_addr registers, range check and auto-increment;
  - registered read data, synchronous write.
- Frame FSM and shift registers stay in the top.

Test Plan:
- Write path: reset; frame 00 + 0x3C, then frame 01 + 0xA5 -> mem[0x3C]=0xA5 one edge after the last payload bit; wr_addr=0x3C.
- Read path: after write test, frame 10 + 0x3C, then frame 11 + 0x00 -> MISO sequence 1,0,1,0,0,1,0,1 in the 8 cycles after E11, then 0.
- Abort: SS_n raised after 5 payload bits of 01 + 0xFF -> frame_err single-cycle pulse; mem[0x3C] still 0xA5; next full frame works.
- Auto-increment, macro on: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_addr=0x01. Macro off: mem[0xFF]=0x22.
- Out-of-range: DATA_WIDTH=12, ADDR_WIDTH=4, MEM_DEPTH=10; write 0xABC to addr 12 -> ignored. Read addr 12 -> MISO twelve zeros. Read addr 3 after writing 0xABC -> 1010_1011_1100.
- Async reset during TX bit 3 -> MISO=0 immediately; FSM IDLE; rd_addr=0.
